// File: rtl/zapper_ctrl.sv
// Light-gun shot controller: trigger debounce, photodiode sync, black/target flash sequence.
// Build option: define ZAPPER_CHEAT_CHECK_EN to reject shots that see light in the black frame.
module zapper_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned DETECT_MIN      = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic trigger,
    input  logic detect,
    input  logic frame_start,
    output logic flash_black,
    output logic flash_target,
    output logic hit,
    output logic miss,
    output logic busy
);

    localparam int unsigned    DbW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DbW-1:0] DbMax  = DbW'(DEBOUNCE_CYCLES);
    localparam logic [15:0]    DetMin = 16'(DETECT_MIN);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StBlack,
        StTarget,
        StResult,
        StCooldown
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     trig_sync_q, det_sync_q;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           db_level, db_level_q, press;
    logic [15:0]    det_cnt_q, det_cnt_d;
    logic           dark_bad_q, dark_bad_d;
    logic           lit_q, lit_d;
    logic           flash_black_q, flash_black_d;
    logic           flash_target_q, flash_target_d;
    logic           hit_q, hit_d;
    logic           miss_q, miss_d;
    logic           busy_q, busy_d;

    // Level is high only once the synced trigger has been stable for the full window.
    assign db_level = (db_cnt_q == DbMax);
    assign press    = db_level && !db_level_q;

    always_comb begin
        db_cnt_d = db_cnt_q;
        if (!trig_sync_q[1]) begin
            db_cnt_d = '0;
        end else if (db_cnt_q != DbMax) begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        dark_bad_d = dark_bad_q;
        lit_d      = lit_q;
        case (state_q)
            StIdle:     if (press) state_d = StArm;
            StArm:      if (frame_start) state_d = StBlack;
            StBlack: begin
                if (frame_start) begin
                    state_d = StTarget;
`ifdef ZAPPER_CHEAT_CHECK_EN
                    dark_bad_d = (det_cnt_q >= DetMin);
`else
                    dark_bad_d = 1'b0;
`endif
                end
            end
            StTarget: begin
                if (frame_start) begin
                    state_d = StResult;
                    lit_d   = (det_cnt_q >= DetMin);
                end
            end
            StResult:   state_d = StCooldown;
            StCooldown: if (!db_level) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Count is per-state: any transition restarts it so each frame is measured alone.
    always_comb begin
        det_cnt_d = det_cnt_q;
        if (state_d != state_q) begin
            det_cnt_d = '0;
        end else if ((state_q == StBlack || state_q == StTarget) && det_sync_q[1]
                     && det_cnt_q != 16'hFFFF) begin
            det_cnt_d = det_cnt_q + 16'd1;
        end
    end

    always_comb begin
        flash_black_d  = (state_d == StBlack);
        flash_target_d = (state_d == StTarget);
        busy_d         = (state_d != StIdle);
        hit_d          = (state_q == StResult) && lit_q && !dark_bad_q;
        miss_d         = (state_q == StResult) && !(lit_q && !dark_bad_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            trig_sync_q    <= '0;
            det_sync_q     <= '0;
            db_cnt_q       <= '0;
            db_level_q     <= 1'b0;
            det_cnt_q      <= '0;
            dark_bad_q     <= 1'b0;
            lit_q          <= 1'b0;
            flash_black_q  <= 1'b0;
            flash_target_q <= 1'b0;
            hit_q          <= 1'b0;
            miss_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            trig_sync_q    <= {trig_sync_q[0], trigger};
            det_sync_q     <= {det_sync_q[0], detect};
            db_cnt_q       <= db_cnt_d;
            db_level_q     <= db_level;
            det_cnt_q      <= det_cnt_d;
            dark_bad_q     <= dark_bad_d;
            lit_q          <= lit_d;
            flash_black_q  <= flash_black_d;
            flash_target_q <= flash_target_d;
            hit_q          <= hit_d;
            miss_q         <= miss_d;
            busy_q         <= busy_d;
        end
    end

    assign flash_black  = flash_black_q;
    assign flash_target = flash_target_q;
    assign hit          = hit_q;
    assign miss         = miss_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_zapper_ctrl.sv
// Scoreboard bench for zapper_ctrl: expected verdicts queued per shot, popped on hit/miss pulses.
module tb_zapper_ctrl;

    logic clk = 1'b0;
    logic reset, trigger, detect, frame_start;
    logic flash_black, flash_target, hit, miss, busy;

    int n_checks   = 0;
    int n_errors   = 0;
    int cyc        = 0;
    int fs_cyc     = -100;
    int fcnt       = 0;
    int n_verdicts = 0;
    int n_expected = 0;
    logic [1:0] exp_q[$];

    zapper_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .DETECT_MIN     (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .trigger     (trigger),
        .detect      (detect),
        .frame_start (frame_start),
        .flash_black (flash_black),
        .flash_target(flash_target),
        .hit         (hit),
        .miss        (miss),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame generator plus verdict monitor; outputs sampled at negedge, inputs driven there.
    always @(negedge clk) begin
        logic [1:0] v;
        cyc++;
        if (hit || miss) begin
            n_verdicts++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_verdict", 32'({hit, miss}), 32'd0);
            end else begin
                v = exp_q.pop_front();
                check_eq("verdict", 32'({hit, miss}), 32'(v));
                check_eq("verdict_latency", 32'(cyc - fs_cyc), 32'd2);
            end
        end
        fcnt = (fcnt == 99) ? 0 : fcnt + 1;
        frame_start = (fcnt == 99);
        if (frame_start) fs_cyc = cyc;
    end

    task automatic expect_verdict(input bit exp_hit);
        exp_q.push_back(exp_hit ? 2'b10 : 2'b01);
        n_expected++;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 600) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(busy), 32'd0);
    endtask

    task automatic run_shot(input string tag, input int bdet, input int tdet,
                            input bit exp_hit, input bit hold);
        int n;
        expect_verdict(exp_hit);
        trigger = 1'b1;
        repeat (10) @(negedge clk);
        if (!hold) trigger = 1'b0;
        n = 0;
        while (!flash_black && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_black_start"}, 32'(flash_black), 32'd1);
        n = 0;
        while (flash_black && n < 200) begin
            detect = (n >= 20 && n < 20 + bdet);
            @(negedge clk);
            n++;
        end
        detect = 1'b0;
        check_eq({tag, "_black_len"}, 32'(n), 32'd100);
        check_eq({tag, "_target_start"}, 32'(flash_target), 32'd1);
        n = 0;
        while (flash_target && n < 200) begin
            if (flash_black) check_eq({tag, "_flash_overlap"}, 32'd1, 32'd0);
            detect = (n >= 20 && n < 20 + tdet);
            @(negedge clk);
            n++;
        end
        detect = 1'b0;
        check_eq({tag, "_target_len"}, 32'(n), 32'd100);
        repeat (5) @(negedge clk);
        check_eq({tag, "_verdict_seen"}, 32'(exp_q.size()), 32'd0);
        if (!hold) wait_idle({tag, "_idle"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] acc;
        reset   = 1'b1;
        trigger = 1'b0;
        detect  = 1'b0;
        frame_start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", 32'({busy, flash_black, flash_target, hit, miss}), 32'd0);
        reset = 1'b0;

        acc = '0;
        repeat (500) begin
            @(negedge clk);
            acc |= {busy, flash_black, flash_target, hit, miss};
        end
        check_eq("idle_outputs", 32'(acc), 32'd0);

        // Too short to pass debounce.
        trigger = 1'b1;
        repeat (3) @(negedge clk);
        trigger = 1'b0;
        acc = '0;
        repeat (20) begin
            @(negedge clk);
            acc[4] |= busy;
        end
        check_eq("short_press_busy", 32'(acc), 32'd0);

        // Press latency, then let the sequence finish as a dark miss.
        expect_verdict(1'b0);
        trigger = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 6) check_eq("busy_latency_6", 32'(busy), 32'd0);
            if (i == 7) check_eq("busy_latency_7", 32'(busy), 32'd1);
        end
        trigger = 1'b0;
        wait_idle("latency_shot_idle");
        check_eq("latency_shot_verdict", 32'(exp_q.size()), 32'd0);

        run_shot("hit", 0, 5, 1'b1, 1'b0);
        run_shot("miss", 0, 2, 1'b0, 1'b0);
`ifdef ZAPPER_CHEAT_CHECK_EN
        run_shot("cheat", 10, 10, 1'b0, 1'b0);
`else
        run_shot("cheat", 10, 10, 1'b1, 1'b0);
`endif

        // Held trigger: one verdict, then cooldown until release.
        run_shot("hold", 0, 5, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        check_eq("hold_cooldown_busy", 32'(busy), 32'd1);
        trigger = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("hold_release_idle", 32'(busy), 32'd0);

        // Reset during TARGET: everything drops, no verdict follows.
        trigger = 1'b1;
        repeat (10) @(negedge clk);
        trigger = 1'b0;
        begin
            int n = 0;
            while (!flash_target && n < 400) begin
                @(negedge clk);
                n++;
            end
        end
        check_eq("abort_target_reached", 32'(flash_target), 32'd1);
        detect = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort_outputs", 32'({busy, flash_black, flash_target, hit, miss}), 32'd0);
        detect = 1'b0;
        reset  = 1'b0;
        repeat (300) @(negedge clk);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("verdict_count", 32'(n_verdicts), 32'(n_expected));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/zapper_ctrl.md
# zapper_ctrl

Light-gun shot controller for the Duck Hunt display path. It synchronizes and debounces the raw trigger, synchronizes the photodiode detect, and runs the frame-locked flash sequence: one black frame, then one target frame. It emits a one-cycle hit or miss verdict. It sits upstream of pattern_gen, which draws the black or target-white frame as commanded by `flash_black` and `flash_target`. It takes frame boundaries from the vga block's `screen_reset` pulse.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: stable-high clk cycles required on synced trigger before a press is accepted (~10 ms at 25.175 MHz).
- `DETECT_MIN`, default 64: detect-high clk cycles within one frame that count as "light seen".
- `clk`  input  1  pixel clock from the PLL. Single clock domain.
- `reset`  input  1  asynchronous, active-high. Clears all state.
- `trigger`  input  1  raw gun trigger, active-high, asynchronous to clk.
- `detect`  input  1  raw photodiode output, active-high (1 = light seen), asynchronous to clk.
- `frame_start`  input  1  one-cycle pulse at the start of each frame (vga `screen_reset`).
- `flash_black`  output  1  pattern_gen draws an all-black frame.
- `flash_target`  output  1  pattern_gen draws black with the target box white.
- `hit`  output  1  one-cycle pulse: shot on target.
- `miss`  output  1  one-cycle pulse: shot missed or rejected.
- `busy`  output  1  high in every state except IDLE.

## Operation
- `trigger` and `detect` each pass through a 2-flop synchronizer; all logic uses the synced versions.
- Debounce: the counter resets whenever synced trigger is low and increments while it is high, saturating at `DEBOUNCE_CYCLES`. The debounced level is high when the counter is at saturation. A press is the rising edge of the debounced level.
- Detect counter: 16-bit, saturating at 0xFFFF. It cleared on every state transition and increments on each clk cycle where synced detect = 1 in BLACK and TARGET.
- FSM states:
  - IDLE → ARM on press.
  - ARM → BLACK on `frame_start`.
  - BLACK → TARGET on `frame_start`. Latch `dark_bad` = (count ≥ `DETECT_MIN`).
  - TARGET → RESULT on `frame_start`. Latch `lit` = (count ≥ `DETECT_MIN`).
  - RESULT → COOLDOWN unconditionally. Assert `hit` if `lit` && !`dark_bad`, else assert `miss`.
  - COOLDOWN → IDLE when the debounced trigger is low.
- Output decode: `flash_black` = (state == BLACK); `flash_target` = (state == TARGET). They are never both high.
- `hit` and `miss` are mutually exclusive and exactly one pulses per accepted press.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0; synchronizers 0.
- All outputs are registered.
- Trigger latency: a trigger held high becomes a press `2 + DEBOUNCE_CYCLES` cycles after its first sampled high.
- Flash outputs change in the cycle after the `frame_start` pulse, so each flash spans exactly one full frame.
- `hit`/`miss` assert exactly 2 cycles after the `frame_start` that ends TARGET (entry to RESULT, then the pulse) and last 1 cycle.
- A press in the same cycle as `frame_start` enters ARM; that pulse is not consumed, and BLACK starts on the next `frame_start`.
- Presses while `busy` are ignored. COOLDOWN blocks auto-repeat from a held trigger.
- Counter saturation: neither counter wraps.
- Asserting `reset` mid-sequence returns to IDLE immediately, with flash outputs low and no verdict emitted.

## Configuration
- `ZAPPER_CHEAT_CHECK_EN` defined: the BLACK-frame check is active. Light seen during the black frame (`dark_bad`) forces `miss`, rejecting a gun aimed at a lamp.
- `ZAPPER_CHEAT_CHECK_EN` undefined: the black frame is still drawn, but `dark_bad` is tied to 0 and the BLACK-frame detect count is ignored; the verdict depends only on `lit`.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `DETECT_MIN`=3, `frame_start` every 100 cycles.
- Reset, then idle 500 cycles → `busy`, `flash_*`, `hit`, `miss` all stay 0.
- Trigger high 3 cycles, then low → no press, `busy` stays 0. Trigger held 10 cycles → `busy`=1 exactly 7 cycles after the first sampled high.
- Hit: press; detect low in BLACK; detect high for 5 cycles in TARGET → `flash_black` high for 100 cycles, then `flash_target` high for 100 cycles; `hit` pulses 1 cycle at 2 cycles after the TARGET-ending `frame_start`.
- Miss: press; detect high for only 2 cycles in TARGET → single `miss` pulse, no `hit`.
- Cheat, macro on: detect high 10 cycles in BLACK and 10 in TARGET → `miss`. Same stimulus with the macro off → `hit`.
- Hold trigger through the whole sequence → exactly one verdict; `busy` stays 1 in COOLDOWN until trigger release. Assert `reset` during TARGET → all outputs 0 next cycle, no verdict.
